// File: rtl/csat_enum_sequencer.sv
// ---------------------------------------------------------------------------
// csat_enum_sequencer
// Brute-force circuit-SAT search controller. Walks every N_IN-bit candidate
// through one combinational benchmark circuit (CUT), matches each CUT result
// against the candidate that produced it PIPE cycles earlier, and reports the
// first hit or, in find-all mode, every hit (one per host handshake), plus an
// UNSAT verdict when the run finds nothing.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle run request, honoured only in IDLE or DONE
//   mode_all       sampled at start: 0 = stop at first hit, 1 = find all
//   sol_ack        host consumed `solution` (acted on only in HOLD)
//   cand           candidate assignment to the CUT inputs
//   cut_sat        CUT output, PIPE cycles behind `cand`
//   busy           run in progress (SEARCH, DRAIN, HOLD)
//   sol_valid      `solution` holds a satisfying assignment
//   solution       latched satisfying assignment
//   sol_count      hits found in the current run
//   done, unsat    run complete; unsat when no hit was found
// ---------------------------------------------------------------------------
module csat_enum_sequencer #(
   parameter int unsigned N_IN = 7,
   parameter int unsigned PIPE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            mode_all,
   input  logic            sol_ack,
   output logic [N_IN-1:0] cand,
   input  logic            cut_sat,
   output logic            busy,
   output logic            sol_valid,
   output logic [N_IN-1:0] solution,
   output logic [N_IN:0]   sol_count,
   output logic            done,
   output logic            unsat
);

   localparam logic [N_IN-1:0] CAND_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_DRAIN,
      ST_HOLD,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   cand_q, cand_d;
   logic              mode_q, mode_d;
   logic [N_IN-1:0]   resume_q, resume_d;
   logic [N_IN-1:0]   solution_q, solution_d;
   logic              sol_valid_q, sol_valid_d;
   logic [N_IN:0]     sol_count_q, sol_count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              unsat_q, unsat_d;

   logic              issuing;
   logic              hit;
   logic              squash;
   logic              tag_vld;
   logic [N_IN-1:0]   tag_cand;
   logic              younger_vld;

   assign issuing = (state_q == ST_SEARCH);
   assign hit     = cut_sat & tag_vld;
   // A hit retires the tag and kills every younger in-flight candidate.
   assign squash  = hit & ((state_q == ST_SEARCH) | (state_q == ST_DRAIN));

   // Tag pipeline: remembers which candidate each cut_sat sample belongs to.
   if (PIPE == 0) begin : g_no_pipe
      assign tag_vld     = issuing;
      assign tag_cand    = cand_q;
      assign younger_vld = 1'b0;
   end else begin : g_pipe
      logic [PIPE-1:0] vld_q, vld_d;
      logic [N_IN-1:0] tc_q [PIPE];
      logic [N_IN-1:0] tc_d [PIPE];

      always_comb begin
         vld_d[0] = issuing & ~squash;
         tc_d[0]  = cand_q;
         for (int k = 1; k < int'(PIPE); k++) begin
            vld_d[k] = vld_q[k-1] & ~squash;
            tc_d[k]  = tc_q[k-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < int'(PIPE); k++) begin
               tc_q[k] <= '0;
            end
         end else begin
            vld_q <= vld_d;
            for (int k = 0; k < int'(PIPE); k++) begin
               tc_q[k] <= tc_d[k];
            end
         end
      end

      assign tag_vld  = vld_q[PIPE-1];
      assign tag_cand = tc_q[PIPE-1];

      // Stages younger than the tag; empty means the drain is complete.
      if (PIPE == 1) begin : g_one
         assign younger_vld = 1'b0;
      end else begin : g_many
         assign younger_vld = |vld_q[PIPE-2:0];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      mode_d      = mode_q;
      resume_d    = resume_q;
      solution_d  = solution_q;
      sol_valid_d = sol_valid_q;
      sol_count_d = sol_count_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               cand_d      = '0;
               sol_count_d = '0;
               sol_valid_d = 1'b0;
               mode_d      = mode_all;
               state_d     = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            // The last candidate holds; it does not wrap to zero.
            if (cand_q == CAND_MAX) begin
               state_d = (PIPE == 0) ? ST_DONE : ST_DRAIN;
            end else begin
               cand_d = cand_q + N_IN'(1);
            end
         end
         ST_DRAIN: begin
            if (!younger_vld) begin
               state_d = ST_DONE;
            end
         end
         ST_HOLD: begin
            if (sol_ack) begin
               sol_valid_d = 1'b0;
               cand_d      = resume_q;
               state_d     = ST_SEARCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A hit overrides the normal SEARCH/DRAIN progression.
      if (squash) begin
         solution_d  = tag_cand;
         sol_valid_d = 1'b1;
         sol_count_d = sol_count_q + (N_IN+1)'(1);
         resume_d    = tag_cand + N_IN'(1);
         if (!mode_q || (tag_cand == CAND_MAX)) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_HOLD;
         end
      end

      busy_d  = (state_d == ST_SEARCH) || (state_d == ST_DRAIN) || (state_d == ST_HOLD);
      done_d  = (state_d == ST_DONE);
      unsat_d = done_d && (sol_count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cand_q      <= '0;
         mode_q      <= 1'b0;
         resume_q    <= '0;
         solution_q  <= '0;
         sol_valid_q <= 1'b0;
         sol_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         unsat_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         mode_q      <= mode_d;
         resume_q    <= resume_d;
         solution_q  <= solution_d;
         sol_valid_q <= sol_valid_d;
         sol_count_q <= sol_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         unsat_q     <= unsat_d;
      end
   end

   assign cand      = cand_q;
   assign busy      = busy_q;
   assign sol_valid = sol_valid_q;
   assign solution  = solution_q;
   assign sol_count = sol_count_q;
   assign done      = done_q;
   assign unsat     = unsat_q;

endmodule
